// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a single BRAM with one write and one read port.
// Writes and reads arbitrate independently; each requester owns one read-response slot.
module bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            wr_valid,
  output logic [1:0]            wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr0,
  input  logic [ADDR_WIDTH-1:0] wr_addr1,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic [1:0]            rd_valid,
  output logic [1:0]            rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data0,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic                  bram_we,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_HOLD     = 2'd2
  } slot_state_t;

  logic                  wr_ptr_reg, wr_ptr_next;
  logic                  rd_ptr_reg, rd_ptr_next;
  logic [1:0]            wr_gnt;
  logic [1:0]            rd_elig;
  logic [1:0]            rd_cand;
  logic                  rd_stall;
  logic [ADDR_WIDTH-1:0] rd_cand_addr;
  logic [1:0]            slot_idle;
  logic [1:0]            rd_fire;
  logic [1:0]            rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_data_arr [2];

  // Write arbitration: sole requester wins, otherwise the pointer decides.
  assign wr_gnt[0] = wr_valid[0] & (~wr_valid[1] | ~wr_ptr_reg);
  assign wr_gnt[1] = wr_valid[1] & (~wr_valid[0] |  wr_ptr_reg);
  assign wr_ready  = wr_gnt & {2{rst_n}};

  assign bram_we    = |(wr_valid & wr_ready);
  assign bram_waddr = wr_ready[1] ? wr_addr1 : wr_addr0;
  assign bram_din   = wr_ready[1] ? wr_data1 : wr_data0;

  // Read arbitration over requesters whose response slot is free.
  assign rd_elig      = rd_valid & slot_idle;
  assign rd_cand[0]   = rd_elig[0] & (~rd_elig[1] | ~rd_ptr_reg);
  assign rd_cand[1]   = rd_elig[1] & (~rd_elig[0] |  rd_ptr_reg);
  assign rd_cand_addr = rd_cand[1] ? rd_addr1 : rd_addr0;

  // A read that collides with this cycle's write waits one cycle so it sees the new data.
  assign rd_stall = bram_we & (|rd_cand) & (rd_cand_addr == bram_waddr);
  assign rd_ready = rd_cand & {2{rst_n & ~rd_stall}};

  assign bram_re    = |(rd_valid & rd_ready);
  assign bram_raddr = rd_ready[1] ? rd_addr1 : rd_addr0;

  assign rd_fire  = rd_valid & rd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (&wr_valid)
      wr_ptr_next = wr_ready[0];
    if ((&rd_elig) && !rd_stall)
      rd_ptr_next = rd_ready[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      slot_state_t           state_reg, state_next;
      logic [DATA_WIDTH-1:0] data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= SLOT_IDLE;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          if (state_reg == SLOT_INFLIGHT)
            data_reg <= bram_dout;
        end
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          SLOT_IDLE:     if (rd_fire[gi]) state_next = SLOT_INFLIGHT;
          SLOT_INFLIGHT: state_next = SLOT_HOLD;
          SLOT_HOLD:     if (rsp_fire[gi]) state_next = SLOT_IDLE;
          default:       state_next = SLOT_IDLE;
        endcase
      end

      assign slot_idle[gi]    = (state_reg == SLOT_IDLE);
      assign rsp_valid[gi]    = (state_reg == SLOT_HOLD);
      assign rsp_data_arr[gi] = data_reg;
    end
  endgenerate

  assign rsp_data0 = rsp_data_arr[0];
  assign rsp_data1 = rsp_data_arr[1];

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: behavioural BRAM, cycle model with per-cycle
// comparison, and literal expectations for each scenario.
module tb_bram_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1, bram_waddr, bram_raddr;
  logic [DW-1:0] wr_data0, wr_data1, rsp_data0, rsp_data1, bram_din, bram_dout;
  logic          bram_we, bram_re;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .bram_we(bram_we), .bram_re(bram_re),
    .bram_waddr(bram_waddr), .bram_raddr(bram_raddr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Read-first synchronous memory standing in for the BRAM.
  logic [DW-1:0] bmem [256];
  always @(posedge clk) begin
    if (bram_re) bram_dout <= bmem[bram_raddr];
    if (bram_we) bmem[bram_waddr] <= bram_din;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Reference model: outstanding reads are tracked as (busy, issue cycle, data).
  int            cyc = 0;
  int            m_wptr = 0, m_rptr = 0;
  bit            busy [2];
  int            issue [2];
  logic [DW-1:0] sdata [2];
  logic [DW-1:0] mmem [256];

  always @(negedge clk) begin : model
    int            wwin, rcand, rwin;
    bit            stall, ev;
    bit            elig [2];
    logic [1:0]    e_wr, e_rd;
    logic [AW-1:0] e_waddr, c_addr;
    logic [DW-1:0] e_din;
    if (!rst_n) begin
      chk("M_rst_wr_ready", wr_ready, 2'b00);
      chk("M_rst_rd_ready", rd_ready, 2'b00);
      chk("M_rst_rsp_valid", rsp_valid, 2'b00);
      chk("M_rst_we_re", {bram_we, bram_re}, 2'b00);
      chk("M_rst_rsp_data", {rsp_data1, rsp_data0}, 64'd0);
      m_wptr = 0; m_rptr = 0;
      for (int i = 0; i < 2; i++) busy[i] = 1'b0;
    end else begin
      wwin = -1;
      if (wr_valid == 2'b11) wwin = m_wptr;
      else if (wr_valid[0]) wwin = 0;
      else if (wr_valid[1]) wwin = 1;
      e_waddr = (wwin == 1) ? wr_addr1 : wr_addr0;
      e_din   = (wwin == 1) ? wr_data1 : wr_data0;
      for (int i = 0; i < 2; i++) elig[i] = rd_valid[i] && !busy[i];
      rcand = -1;
      if (elig[0] && elig[1]) rcand = m_rptr;
      else if (elig[0]) rcand = 0;
      else if (elig[1]) rcand = 1;
      c_addr = (rcand == 1) ? rd_addr1 : rd_addr0;
      stall = (wwin >= 0) && (rcand >= 0) && (c_addr == e_waddr);
      rwin = stall ? -1 : rcand;
      e_wr = 2'b00; if (wwin >= 0) e_wr[wwin] = 1'b1;
      e_rd = 2'b00; if (rwin >= 0) e_rd[rwin] = 1'b1;

      chk("M_wr_ready", wr_ready, e_wr);
      chk("M_bram_we", bram_we, (wwin >= 0));
      if (wwin >= 0) chk("M_bram_wdata", {bram_waddr, bram_din}, {e_waddr, e_din});
      chk("M_rd_ready", rd_ready, e_rd);
      chk("M_bram_re", bram_re, (rwin >= 0));
      if (rwin >= 0) chk("M_bram_raddr", bram_raddr, c_addr);
      for (int i = 0; i < 2; i++) begin
        ev = busy[i] && (cyc >= issue[i] + 2);
        chk("M_rsp_valid", rsp_valid[i], ev);
        if (ev) chk("M_rsp_data", (i == 0) ? rsp_data0 : rsp_data1, sdata[i]);
        if (ev && rsp_ready[i]) busy[i] = 1'b0;
      end

      if (wr_valid == 2'b11) m_wptr = 1 - wwin;
      if (elig[0] && elig[1] && !stall) m_rptr = 1 - rcand;
      if (rwin >= 0) begin
        busy[rwin]  = 1'b1;
        issue[rwin] = cyc;
        sdata[rwin] = mmem[c_addr];
      end
      if (wwin >= 0) mmem[e_waddr] = e_din;
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    wr_valid = 2'b11; rd_valid = 2'b11; rsp_ready = 2'b11;
    wr_addr0 = '0; wr_addr1 = '0; rd_addr0 = '0; rd_addr1 = '0;
    wr_data0 = '0; wr_data1 = '0;
    #1 rst_n = 1'b0;

    // Reset holds every handshake low even with requests pending.
    sample();
    chk("R_wr_ready", wr_ready, 2'b00);
    chk("R_rd_ready", rd_ready, 2'b00);
    chk("R_rsp_valid", rsp_valid, 2'b00);
    chk("R_we_re", {bram_we, bram_re}, 2'b00);
    next_cycle();
    sample();
    next_cycle();

    // Both write continuously: grants alternate starting with r0.
    rst_n = 1'b1; rd_valid = 2'b00;
    wr_addr0 = 8'h10; wr_data0 = 32'hAAAA0000;
    wr_addr1 = 8'h20; wr_data1 = 32'hBBBB0000;
    wr_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("A_wr_ready", wr_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("A_bram_we", bram_we, 1'b1);
      chk("A_waddr", bram_waddr, (k % 2 == 0) ? 8'h10 : 8'h20);
      $display("[TB] A cycle %0d wr_ready=%b waddr=0x%0h", k, wr_ready, bram_waddr);
      next_cycle();
    end
    wr_valid = 2'b00;

    // Write 0x5 to 0x33 by r1, read back by r0 one cycle later.
    wr_valid = 2'b10; wr_addr1 = 8'h33; wr_data1 = 32'h5;
    sample(); chk("B_wr_ready", wr_ready, 2'b10); next_cycle();
    wr_valid = 2'b00; rd_valid = 2'b01; rd_addr0 = 8'h33;
    sample(); chk("B_rd_ready", rd_ready, 2'b01); next_cycle();
    rd_valid = 2'b00;
    sample(); chk("B_rsp_valid_c2", rsp_valid[0], 1'b0); next_cycle();
    sample();
    chk("B_rsp_valid_c3", rsp_valid[0], 1'b1);
    chk("B_rsp_data", rsp_data0, 32'h5);
    $display("[TB] B rsp_valid0=%b rsp_data0=0x%0h", rsp_valid[0], rsp_data0);
    next_cycle();

    // Same-address write and read in one cycle: read stalls, then sees new data.
    wr_valid = 2'b01; wr_addr0 = 8'h40; wr_data0 = 32'h12345678;
    rd_valid = 2'b10; rd_addr1 = 8'h40;
    sample();
    chk("C_rd_ready_stall", rd_ready, 2'b00);
    chk("C_wr_ready", wr_ready, 2'b01);
    next_cycle();
    wr_valid = 2'b00;
    sample(); chk("C_rd_ready_retry", rd_ready, 2'b10); next_cycle();
    rd_valid = 2'b00;
    sample(); next_cycle();
    sample();
    chk("C_rsp_valid", rsp_valid[1], 1'b1);
    chk("C_rsp_data", rsp_data1, 32'h12345678);
    $display("[TB] C rsp_valid1=%b rsp_data1=0x%0h", rsp_valid[1], rsp_data1);
    next_cycle();

    // r0 back-pressures its response while r1 keeps reading.
    rsp_ready = 2'b10; rd_valid = 2'b01; rd_addr0 = 8'h10;
    sample(); chk("D_rd_ready", rd_ready, 2'b01); next_cycle();
    rd_valid = 2'b00;
    sample(); next_cycle();
    sample();
    chk("D_rsp_valid0", rsp_valid[0], 1'b1);
    chk("D_rsp_data0", rsp_data0, 32'hAAAA0000);
    next_cycle();
    rd_valid = 2'b11; rd_addr1 = 8'h20;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("D_hold_valid", rsp_valid[0], 1'b1);
      chk("D_hold_data", rsp_data0, 32'hAAAA0000);
      chk("D_rd_ready0", rd_ready[0], 1'b0);
      chk("D_r1_ready", rd_ready[1], (k % 3 == 0));
      chk("D_r1_rsp", rsp_valid[1], (k % 3 == 2));
      if (k == 2) chk("D_r1_data", rsp_data1, 32'hBBBB0000);
      $display("[TB] D cycle %0d rsp_valid=%b rd_ready=%b", k, rsp_valid, rd_ready);
      next_cycle();
    end
    rsp_ready = 2'b11; rd_valid = 2'b00;
    repeat (4) begin sample(); next_cycle(); end

    // Both read continuously: one response per requester every three cycles.
    rd_valid = 2'b11; rd_addr0 = 8'h10; rd_addr1 = 8'h20;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 30; k++) begin
      sample();
      chk("E_rd_ready", rd_ready, (k % 3 == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b10 : 2'b00));
      if (rsp_valid[0]) begin n0++; chk("E_data0", rsp_data0, 32'hAAAA0000); end
      if (rsp_valid[1]) begin n1++; chk("E_data1", rsp_data1, 32'hBBBB0000); end
      next_cycle();
    end
    chk("E_count0", n0, 10);
    chk("E_count1", n1, 9);
    $display("[TB] E responses r0=%0d r1=%0d", n0, n1);
    rd_valid = 2'b00;
    repeat (3) begin sample(); next_cycle(); end

    // Reset right after a read handshake, with both pointers moved to 1.
    wr_addr0 = 8'h50; wr_data0 = 32'h11111111;
    wr_addr1 = 8'h60; wr_data1 = 32'h22222222;
    wr_valid = 2'b11; rd_valid = 2'b10; rd_addr1 = 8'h20;
    sample();
    chk("F_wr_ready", wr_ready, 2'b01);
    chk("F_rd_ready", rd_ready, 2'b10);
    next_cycle();
    rst_n = 1'b0; rd_valid = 2'b00;
    sample();
    chk("F_rst_ready", {wr_ready, rd_ready}, 4'b0000);
    chk("F_rst_rsp_valid", rsp_valid, 2'b00);
    chk("F_rst_we_re", {bram_we, bram_re}, 2'b00);
    next_cycle();
    rst_n = 1'b1; wr_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      sample(); chk("F_no_rsp", rsp_valid, 2'b00); next_cycle();
    end
    wr_valid = 2'b11; rd_valid = 2'b11; rd_addr0 = 8'h10; rd_addr1 = 8'h20;
    sample();
    chk("F_wptr_reset", wr_ready, 2'b01);
    chk("F_rptr_reset", rd_ready, 2'b01);
    $display("[TB] F after reset wr_ready=%b rd_ready=%b", wr_ready, rd_ready);
    next_cycle();
    wr_valid = 2'b00; rd_valid = 2'b00;
    repeat (4) begin sample(); next_cycle(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: BRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8: BRAM address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wr_valid[1:0], wr_ready[1:0]  in/out  2 each  per-requester write handshake.
REQ-007 wr_addr0/1  in  ADDR_WIDTH  write address; wr_data0/1  in  DATA_WIDTH  write data.
REQ-008 rd_valid[1:0], rd_ready[1:0]  in/out  2 each  per-requester read-request handshake; rd_addr0/1  in  ADDR_WIDTH.
REQ-009 rsp_valid[1:0] out, rsp_ready[1:0] in  2 each  per-requester read-response handshake; rsp_data0/1  out  DATA_WIDTH.
REQ-010 bram_we, bram_re  out  1  BRAM strobes; bram_waddr, bram_raddr  out  ADDR_WIDTH; bram_din  out  DATA_WIDTH; bram_dout  in  DATA_WIDTH.

Function
REQ-011 The BRAM read data SHALL be valid in the cycle after bram_re. A simultaneous read and write to one address SHALL return the old data.
REQ-012 Write port arbitration: wr_ready[i] SHALL be 1 only for the granted requester. The grant goes to the sole requester, or to the wr round-robin pointer when both request.
REQ-013 After a write grant to requester i while both requested, the wr pointer SHALL move to 1-i. Otherwise it SHALL hold.
REQ-014 bram_we SHALL equal |(wr_valid & wr_ready), with bram_waddr/bram_din muxed from the granted requester, combinationally in the same cycle.
REQ-015 Each requester SHALL have a read slot FSM: IDLE -> INFLIGHT on a read handshake; INFLIGHT -> HOLD next cycle, capturing bram_dout into rsp_data_i; HOLD -> IDLE on rsp_valid_i & rsp_ready_i.
REQ-016 A requester SHALL be read-eligible only when its slot is IDLE and rd_valid_i=1.
REQ-017 Read port arbitration SHALL be the same as REQ-012/013, using a separate rd round-robin pointer over eligible requesters.
REQ-018 Hazard stall: if the read candidate's rd_addr equals the address of the write granted in the same cycle, rd_ready SHALL be 0 for that cycle. The rd pointer SHALL not move.
REQ-019 bram_re SHALL equal |(rd_valid & rd_ready), with bram_raddr muxed from the granted requester.
REQ-020 rsp_valid_i SHALL be 1 exactly while slot i is HOLD. rsp_data_i SHALL be stable while rsp_valid_i=1 and rsp_ready_i=0.
REQ-021 Read latency SHALL be 2 cycles: handshake in cycle C gives rsp_valid in C+2.
REQ-022 Each requester SHALL have at most one outstanding read. Only one BRAM read SHALL be issued per cycle.
REQ-023 Read and write ports SHALL arbitrate independently. One write and one read (same or different requesters) MAY complete in the same cycle.
REQ-024 Response acceptance (HOLD->IDLE) and a new request from the same requester SHALL not overlap. The new read becomes eligible the cycle after the slot returns to IDLE.
REQ-025 wr_ready/rd_ready SHALL not depend on rsp_ready.

Reset
REQ-026 While rst_n=0: wr_ready=0, rd_ready=0, rsp_valid=0, bram_we=0, bram_re=0.
REQ-027 Reset SHALL set both slots to IDLE, rsp_data to 0, and both round-robin pointers to requester 0.
REQ-028 Reset asserted mid-read SHALL discard the INFLIGHT/HOLD data. No rsp_valid SHALL appear after release until a new handshake.
REQ-029 Reset SHALL not affect BRAM contents.

Verification
REQ-030 Both requesters write continuously (r0 addr 0x10 data 0xAAAA0000, r1 addr 0x20 data 0xBBBB0000) from reset -> grants alternate r0,r1,r0,...; bram_we=1 every cycle.
REQ-031 r1 writes 0x5 to addr 0x33 in cycle C, r0 reads addr 0x33 in cycle C+1 -> rsp_valid0 in C+3, rsp_data0=0x5.
REQ-032 r0 write addr 0x40 and r1 read addr 0x40 requested in the same cycle -> rd_ready1=0 that cycle; read granted the next cycle; r1 receives the new data.
REQ-033 r0 holds rsp_ready0=0 for 5 cycles after a response -> rsp_data0 stable, rd_ready0=0, and r1 reads still complete with 2-cycle latency.
REQ-034 Both requesters issue reads continuously with rsp_ready=1 -> grants alternate; each requester gets one response per 3 cycles; no response is lost or misrouted.
REQ-035 rst_n pulsed low in the cycle after a read handshake -> no rsp_valid after release; all outputs at reset values; pointers at requester 0.
